// File: rtl/servo_slew_pwm.sv
`default_nettype none
// ============================================================================
// Module   : servo_slew_pwm
// Purpose  : Multi-channel hobby-servo PWM driver with per-frame slew
//            limiting. Each channel's angle command (0..180 degrees, larger
//            values clamp to 180) is mapped linearly onto a pulse width in
//            [MIN_PW, MAX_PW]. The active pulse width ramps toward that
//            target by at most STEP clocks per PWM frame.
// Ports    : CLK          - system clock, rising edge
//            RST          - asynchronous active-high reset
//            ang_i        - packed angle commands, channel i at [i*ANG_W +: ANG_W]
//            load_i       - latch every ang_i field as a new target
//            en_i         - output enable, low forces every pwm_o bit low
//            pwm_o        - registered servo PWM outputs
//            cur_pw_o     - current ramped pulse width per channel (packed)
//            at_target_o  - bit i high when channel i has reached its target
//            frame_o      - high while the period counter is 0
// Revision : 1.0 - initial release
// ============================================================================
module servo_slew_pwm #(
  parameter int N_CH   = 4,
  parameter int ANG_W  = 8,
  parameter int PW_W   = 20,
  parameter int PERIOD = 1000000,
  parameter int MIN_PW = 25000,
  parameter int MAX_PW = 125000,
  parameter int STEP   = 500
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_CH*ANG_W-1:0]  ang_i,
  input  logic                   load_i,
  input  logic                   en_i,
  output logic [N_CH-1:0]        pwm_o,
  output logic [N_CH*PW_W-1:0]   cur_pw_o,
  output logic [N_CH-1:0]        at_target_o,
  output logic                   frame_o
);

  localparam int RANGE   = MAX_PW - MIN_PW;
  // Product a*RANGE needs the angle width plus the bits of RANGE.
  localparam int RANGE_W = (RANGE > 1) ? $clog2(RANGE + 1) : 1;
  localparam int PROD_W  = ANG_W + RANGE_W;

  localparam logic [PW_W-1:0]  C_LAST_CNT = PW_W'(PERIOD - 1);
  localparam logic [PW_W-1:0]  C_MIN_PW   = PW_W'(MIN_PW);
  localparam logic [PW_W-1:0]  C_STEP     = PW_W'(STEP);
  localparam logic [ANG_W-1:0] C_ANG_MAX  = ANG_W'(180);

  // Registered state
  logic [PW_W-1:0] cnt_q, cnt_d;
  logic [PW_W-1:0] tgt_q [N_CH];
  logic [PW_W-1:0] tgt_d [N_CH];
  logic [PW_W-1:0] cur_q [N_CH];
  logic [PW_W-1:0] cur_d [N_CH];
  logic [N_CH-1:0] pwm_q, pwm_d;

  // Combinational helpers
  logic [PW_W-1:0] tgt_calc [N_CH];
  logic            wrap;

  // --------------------------------------------------------------------------
  // Per-channel angle-to-width mapping and output packing
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [ANG_W-1:0]  ang_clamped;
    logic [PROD_W-1:0] prod;

    assign ang_clamped = (ang_i[g*ANG_W +: ANG_W] > C_ANG_MAX) ? C_ANG_MAX
                                                               : ang_i[g*ANG_W +: ANG_W];
    assign prod        = PROD_W'(ang_clamped) * PROD_W'(RANGE);
    // Quotient never exceeds RANGE, so it always fits the pulse-width field.
    assign tgt_calc[g] = C_MIN_PW + PW_W'(prod / PROD_W'(180));

    assign cur_pw_o[g*PW_W +: PW_W] = cur_q[g];
    assign at_target_o[g]           = (cur_q[g] == tgt_q[g]);
  end

  assign pwm_o   = pwm_q;
  assign frame_o = (cnt_q == '0);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    wrap  = (cnt_q == C_LAST_CNT);
    cnt_d = wrap ? '0 : cnt_q + PW_W'(1);
    pwm_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      tgt_d[i] = load_i ? tgt_calc[i] : tgt_q[i];

      // The slew step uses the pre-edge target, so a load coinciding with
      // the wrap only takes effect at the following wrap.
      cur_d[i] = cur_q[i];
      if (wrap) begin
        if (tgt_q[i] >= cur_q[i]) begin
          if ((tgt_q[i] - cur_q[i]) <= C_STEP) cur_d[i] = tgt_q[i];
          else                                  cur_d[i] = cur_q[i] + C_STEP;
        end else begin
          if ((cur_q[i] - tgt_q[i]) <= C_STEP) cur_d[i] = tgt_q[i];
          else                                  cur_d[i] = cur_q[i] - C_STEP;
        end
      end

      // cur_q only changes at the wrap, where cnt_q = PERIOD-1 > cur_q,
      // so every frame carries exactly one whole pulse.
      pwm_d[i] = en_i & (cnt_q < cur_q[i]);
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      pwm_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        tgt_q[i] <= C_MIN_PW;
        cur_q[i] <= C_MIN_PW;
      end
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
      for (int i = 0; i < N_CH; i++) begin
        tgt_q[i] <= tgt_d[i];
        cur_q[i] <= cur_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_servo_slew_pwm.sv
`default_nettype none
// ============================================================================
// Module   : tb_servo_slew_pwm
// Purpose  : Scoreboard bench for servo_slew_pwm. The stimulus process runs
//            one PWM frame per step, optionally loads new angles, and queues
//            the state expected at the next frame start. A monitor pops that
//            record whenever frame_o is seen and checks cur_pw_o, at_target_o
//            and the measured pulse width of the frame just completed.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_servo_slew_pwm;

  localparam int N_CH   = 4;
  localparam int ANG_W  = 8;
  localparam int PW_W   = 20;
  localparam int PERIOD = 2000;
  localparam int MIN_PW = 200;
  localparam int MAX_PW = 1100;
  localparam int STEP   = 100;

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic [N_CH*ANG_W-1:0] ang_i = '0;
  logic                  load_i = 1'b0;
  logic                  en_i = 1'b1;
  logic [N_CH-1:0]       pwm_o;
  logic [N_CH*PW_W-1:0]  cur_pw_o;
  logic [N_CH-1:0]       at_target_o;
  logic                  frame_o;

  servo_slew_pwm #(
    .N_CH(N_CH), .ANG_W(ANG_W), .PW_W(PW_W), .PERIOD(PERIOD),
    .MIN_PW(MIN_PW), .MAX_PW(MAX_PW), .STEP(STEP)
  ) dut (
    .CLK(CLK), .RST(RST), .ang_i(ang_i), .load_i(load_i), .en_i(en_i),
    .pwm_o(pwm_o), .cur_pw_o(cur_pw_o), .at_target_o(at_target_o),
    .frame_o(frame_o)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [N_CH*PW_W-1:0] cur;
    logic [N_CH-1:0]      at;
    bit                   en;
  } rec_t;

  rec_t q[$];
  rec_t rec;
  rec_t prev;
  bit   have_prev = 1'b0;
  int   hi_cnt [N_CH];
  int   total = 0;
  int   bad = 0;
  bit   en_cur = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  always @(negedge CLK) begin
    if (RST) begin
      have_prev = 1'b0;
      for (int i = 0; i < N_CH; i++) hi_cnt[i] = 0;
    end else if (frame_o) begin
      if (have_prev)
        for (int i = 0; i < N_CH; i++)
          check($sformatf("width_ch%0d", i), hi_cnt[i],
                prev.en ? 64'(prev.cur[i*PW_W +: PW_W]) : 64'd0);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL queue_empty: frame start with no expected record");
      end else begin
        rec = q.pop_front();
        for (int i = 0; i < N_CH; i++)
          check($sformatf("cur_pw_ch%0d", i), cur_pw_o[i*PW_W +: PW_W],
                rec.cur[i*PW_W +: PW_W]);
        check("at_target", at_target_o, rec.at);
        prev      = rec;
        have_prev = 1'b1;
      end
      for (int i = 0; i < N_CH; i++) hi_cnt[i] = int'(pwm_o[i]);
    end else begin
      for (int i = 0; i < N_CH; i++) hi_cnt[i] += int'(pwm_o[i]);
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic chk_reset(input string tag);
    logic [N_CH*PW_W-1:0] e;
    for (int i = 0; i < N_CH; i++) e[i*PW_W +: PW_W] = PW_W'(MIN_PW);
    check({tag, "_pwm"},   pwm_o, 0);
    check({tag, "_frame"}, frame_o, 1);
    check({tag, "_at"},    at_target_o, 4'hF);
    check({tag, "_cur"},   cur_pw_o, e);
  endtask

  task automatic release_rst();
    rec_t r;
    for (int i = 0; i < N_CH; i++) r.cur[i*PW_W +: PW_W] = PW_W'(MIN_PW);
    r.at = 4'hF;
    r.en = en_cur;
    q.push_back(r);
    @(posedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);            // frame start, cnt = 0
  endtask

  task automatic mid_reset(input int at_idx, input logic [N_CH-1:0] pwm_before);
    repeat (at_idx) @(negedge CLK);
    check("pre_rst_pwm", pwm_o, pwm_before);
    #2 RST = 1'b1;
    #1 chk_reset("async_rst");
    repeat (2) @(negedge CLK);
    release_rst();
  endtask

  // One frame: enter at a frame-start negedge, leave at the next one.
  task automatic step(input bit ld, input bit wl, input logic [31:0] ang,
                      input bit en_next, input int c0, input int c1,
                      input int c2, input int c3, input logic [3:0] at);
    rec_t r;
    int   idx;
    en_i = en_cur;
    repeat (100) @(negedge CLK);
    idx = 100;
    if (ld) begin
      ang_i  = ang;
      load_i = 1'b1;
      @(negedge CLK);
      load_i = 1'b0;
      idx    = 101;
    end
    r.cur = {PW_W'(c3), PW_W'(c2), PW_W'(c1), PW_W'(c0)};
    r.at  = at;
    r.en  = en_next;
    q.push_back(r);
    en_cur = en_next;
    if (wl) begin
      repeat (PERIOD - 1 - idx) @(negedge CLK);
      ang_i  = ang;
      load_i = 1'b1;           // sampled on the wrap edge
      @(negedge CLK);
      load_i = 1'b0;
    end else begin
      repeat (PERIOD - idx) @(negedge CLK);
    end
    check("frame_align", frame_o, 1);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    repeat (3) @(negedge CLK);
    chk_reset("por");
    release_rst();

    // Idle frames, then reset mid-frame at cnt = 700
    step(0, 0, 32'h0, 1, 200, 200, 200, 200, 4'b1111);
    step(0, 0, 32'h0, 1, 200, 200, 200, 200, 4'b1111);
    mid_reset(700, 4'b0000);

    // ch0 -> 180 (1100), ch1 -> 90 (650, partial last step)
    step(1, 0, {8'd0, 8'd0, 8'd90, 8'd180}, 1,  300, 300, 200, 200, 4'b1100);
    step(0, 0, 32'h0, 1,  400, 400, 200, 200, 4'b1100);
    step(0, 0, 32'h0, 1,  500, 500, 200, 200, 4'b1100);
    step(0, 0, 32'h0, 1,  600, 600, 200, 200, 4'b1100);
    step(0, 0, 32'h0, 1,  700, 650, 200, 200, 4'b1110);
    step(0, 0, 32'h0, 1,  800, 650, 200, 200, 4'b1110);
    step(0, 0, 32'h0, 1,  900, 650, 200, 200, 4'b1110);
    step(0, 0, 32'h0, 1, 1000, 650, 200, 200, 4'b1110);
    step(0, 0, 32'h0, 1, 1100, 650, 200, 200, 4'b1111);

    // ch2 = 255 clamps to 1100
    step(1, 0, {8'd0, 8'd255, 8'd90, 8'd180}, 1, 1100, 650,  300, 200, 4'b1011);
    step(0, 0, 32'h0, 1, 1100, 650,  400, 200, 4'b1011);
    step(0, 0, 32'h0, 1, 1100, 650,  500, 200, 4'b1011);
    step(0, 0, 32'h0, 1, 1100, 650,  600, 200, 4'b1011);
    step(0, 0, 32'h0, 1, 1100, 650,  700, 200, 4'b1011);
    step(0, 0, 32'h0, 1, 1100, 650,  800, 200, 4'b1011);
    step(0, 0, 32'h0, 1, 1100, 650,  900, 200, 4'b1011);
    step(0, 0, 32'h0, 1, 1100, 650, 1000, 200, 4'b1011);
    step(0, 0, 32'h0, 1, 1100, 650, 1100, 200, 4'b1111);

    // ch2 back to 0, with outputs disabled for three frames mid-ramp
    step(1, 0, {8'd0, 8'd0, 8'd90, 8'd180}, 1, 1100, 650, 1000, 200, 4'b1011);
    step(0, 0, 32'h0, 0, 1100, 650,  900, 200, 4'b1011);
    step(0, 0, 32'h0, 0, 1100, 650,  800, 200, 4'b1011);
    step(0, 0, 32'h0, 0, 1100, 650,  700, 200, 4'b1011);
    step(0, 0, 32'h0, 1, 1100, 650,  600, 200, 4'b1011);
    step(0, 0, 32'h0, 1, 1100, 650,  500, 200, 4'b1011);
    step(0, 0, 32'h0, 1, 1100, 650,  400, 200, 4'b1011);
    step(0, 0, 32'h0, 1, 1100, 650,  300, 200, 4'b1011);
    step(0, 0, 32'h0, 1, 1100, 650,  200, 200, 4'b1111);

    // ch3 -> 180 loaded on the wrap edge: old target used for that step
    step(0, 1, {8'd180, 8'd0, 8'd90, 8'd180}, 1, 1100, 650, 200, 200, 4'b0111);
    step(0, 0, 32'h0, 1, 1100, 650, 200, 300, 4'b0111);
    step(0, 0, 32'h0, 1, 1100, 650, 200, 400, 4'b0111);

    // Reset in the middle of a ramp while every output is high
    mid_reset(150, 4'b1111);
    step(0, 0, 32'h0, 1, 200, 200, 200, 200, 4'b1111);
    step(0, 0, 32'h0, 1, 200, 200, 200, 200, 4'b1111);

    repeat (2) @(negedge CLK);
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/servo_slew_pwm.md
# servo_slew_pwm

Multi-channel hobby-servo driver for the robot arm. Converts a per-channel angle command (0°–180°) into a pulse width between `MIN_PW` and `MAX_PW`. It generates the servo PWM frames itself and ramps each channel's pulse width toward its target by at most `STEP` clock cycles per frame, so joints move smoothly instead of jumping. It sits between the joint command logic and the servo pins and replaces fixed two-position pulse-width selection.

## Interface

Parameters:
- `N_CH`, 4, number of servo channels.
- `ANG_W`, 8, width of each angle field in degrees.
- `PW_W`, 20, width of the period counter and pulse-width registers; must hold `PERIOD-1`.
- `PERIOD`, 1000000, PWM frame length in clocks (20 ms at 50 MHz).
- `MIN_PW`, 25000, pulse width for 0° (0.5 ms).
- `MAX_PW`, 125000, pulse width for 180° (2.5 ms).
- `STEP`, 500, maximum pulse-width change per channel per frame. Must be at least 1.
- Legal parameter values satisfy `MIN_PW <= MAX_PW < PERIOD`.

Ports:
- `CLK`, in, 1, system clock. Everything is clocked on the rising edge.
- `RST`, in, 1, asynchronous active-high reset.
- `ang_i`, in, `N_CH*ANG_W`, packed angles; channel i occupies bits `[i*ANG_W +: ANG_W]`.
- `load_i`, in, 1, strobe that latches all of `ang_i` as new targets.
- `en_i`, in, 1, output enable. When 0, all `pwm_o` bits are forced low.
- `pwm_o`, out, `N_CH`, registered servo PWM outputs.
- `cur_pw_o`, out, `N_CH*PW_W`, current (ramped) pulse width of each channel, packed the same way as `ang_i`.
- `at_target_o`, out, `N_CH`, bit i is high when channel i's current width equals its target width.
- `frame_o`, out, 1, one-cycle pulse while the period counter equals 0.

## Operation

- **Period counter `cnt`**
  - Counts 0..`PERIOD-1`, then wraps to 0.
  - It is free-running and independent of `en_i`.
- **Target computation** (on a clock edge with `load_i` = 1, for each channel):
  - Clamp: `a = min(ang, 180)`.
  - `tgt_pw = MIN_PW + floor(a*(MAX_PW-MIN_PW)/180)`.
  - Compute with enough width that there is no overflow: `ANG_W` + bits of `MAX_PW-MIN_PW`.
  - With the default parameters, 1° gives 25555 and 90° gives 75000.
- **Slew update** (only on the edge where `cnt` wraps from `PERIOD-1` to 0, for each channel):
  - If `|tgt_pw - cur_pw| <= STEP`, then `cur_pw <= tgt_pw`.
  - Otherwise `cur_pw` moves `STEP` toward `tgt_pw`.
  - `cur_pw` never overshoots and always stays within [`MIN_PW`, `MAX_PW`].
- **PWM output**: each edge, `pwm_o[i] <= en_i & (cnt < cur_pw[i])`, using the values before the edge.
- `at_target_o[i] = (cur_pw[i] == tgt_pw[i])`, driven from registers.
- **Reset values**:
  - `cnt` = 0.
  - All `tgt_pw` = `cur_pw` = `MIN_PW` (0°).
  - `pwm_o` = 0.
  - `frame_o` = 1 (since `cnt` = 0).
  - `at_target_o` = all ones.
  - `cur_pw_o` = `MIN_PW` on every channel.
- Reset asserted mid-frame or mid-ramp forces all of the above immediately, without waiting for a clock edge. Ramping restarts from `MIN_PW`.

## Timing

- `load_i` sampled high at edge k: the new `tgt_pw` is visible after edge k, and `at_target_o` updates in the same cycle.
- `load_i` on the wrap edge: that edge's slew step uses the old target. The new target takes effect at the next wrap.
- `cur_pw` changes only at the wrap edge. At that edge `pwm_o` samples `cnt = PERIOD-1`, so it is already low, and every frame carries exactly one whole pulse of the width set at the frame start. There are no runt or split pulses.
- `pwm_o[i]` is high in the `cur_pw[i]` consecutive cycles that follow the edges where `cnt` = 0..`cur_pw-1`. It lags `cnt` by one cycle.
- `en_i` takes effect one cycle after it is sampled. Ramping continues while `en_i` = 0.
- Ramp duration from A to B is `ceil(|B-A|/STEP)` frames.

## Test plan

Simulation parameters: `PERIOD`=2000, `MIN_PW`=200, `MAX_PW`=1100, `STEP`=100, `N_CH`=4 (5 clocks per degree).

1. Release reset, no load, then assert `RST` mid-frame at `cnt`=700 → expect:
   - every `pwm_o` is exactly 200 cycles high per 2000-cycle frame;
   - `at_target_o`=4'b1111;
   - on the mid-frame reset, outputs return to their reset values asynchronously.
2. Load ch0=180 → ch0 `cur_pw_o` steps 300, 400, …, 1100 on 9 successive wraps; `at_target_o[0]` rises after the 9th wrap; measured pulse widths match per frame.
3. Load ch1=90 → target 650; `cur_pw` steps 300, 400, 500, 600, 650; final step is a partial step of 50.
4. Load ch2=255 → clamped to 1100. Then load ch2=0 from 1100 → ramps down by 100 per frame to 200 with no undershoot.
5. Hold `en_i`=0 during a ramp → `pwm_o` stays low throughout while `cur_pw_o` still advances. Set `en_i`=1 → first pulse has the current ramped width.
6. Assert `load_i` on the wrap edge with ch3 going 0→180 → that wrap leaves ch3 at 200; the next wrap gives 300.
